// File: rtl/vx_tensor_gather.sv
// Reassembles SIMD-slice operand packets (sid/sop/eop) into one full-warp packet.
// Optional stall counter enabled by defining TENSOR_GATHER_PERF_EN.
module vx_tensor_gather #(
    parameter int unsigned NUM_THREADS = 4,
    parameter int unsigned SIMD_WIDTH  = 2,
    parameter int unsigned XLEN        = 32,
    parameter int unsigned HDR_W       = 64,
    localparam int unsigned SIMD_COUNT = NUM_THREADS / SIMD_WIDTH,
    localparam int unsigned SID_W      = (SIMD_COUNT > 1) ? $clog2(SIMD_COUNT) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [HDR_W-1:0]              in_hdr,
    input  logic [SID_W-1:0]              in_sid,
    input  logic [SIMD_WIDTH-1:0]         in_tmask,
    input  logic [SIMD_WIDTH*XLEN-1:0]    in_rs1_data,
    input  logic [SIMD_WIDTH*XLEN-1:0]    in_rs2_data,
    input  logic [SIMD_WIDTH*XLEN-1:0]    in_rs3_data,
    input  logic                          in_sop,
    input  logic                          in_eop,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [HDR_W-1:0]              out_hdr,
    output logic [NUM_THREADS-1:0]        out_tmask,
    output logic [NUM_THREADS*XLEN-1:0]   out_rs1_data,
    output logic [NUM_THREADS*XLEN-1:0]   out_rs2_data,
    output logic [NUM_THREADS*XLEN-1:0]   out_rs3_data,
    output logic                          proto_err,
    output logic [31:0]                   perf_stalls
);

    localparam int unsigned SLICE_W = SIMD_WIDTH * XLEN;
    localparam int unsigned WARP_W  = NUM_THREADS * XLEN;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GATHER = 2'd1;
    localparam logic [1:0] S_FULL   = 2'd2;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [HDR_W-1:0]       r_hdr,   w_hdr_nxt;
    logic [NUM_THREADS-1:0] r_tmask, w_tmask_nxt;
    logic [WARP_W-1:0]      r_rs1,   w_rs1_nxt;
    logic [WARP_W-1:0]      r_rs2,   w_rs2_nxt;
    logic [WARP_W-1:0]      r_rs3,   w_rs3_nxt;
    logic                   r_proto_err, w_proto_err_nxt;
    logic                   w_in_fire;
    logic                   w_sid_ok;

    assign w_in_fire = in_valid && (r_state != S_FULL);
    assign w_sid_ok  = ({1'b0, in_sid} < (SID_W+1)'(SIMD_COUNT));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_in_fire && in_sop) w_state_nxt = in_eop ? S_FULL : S_GATHER;
            S_GATHER: if (w_in_fire && in_eop) w_state_nxt = S_FULL;
            S_FULL:   if (out_ready)           w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Slice merge: sop restarts the packet, out-of-range sid writes no lanes.
    always_comb begin
        w_hdr_nxt       = r_hdr;
        w_tmask_nxt     = r_tmask;
        w_rs1_nxt       = r_rs1;
        w_rs2_nxt       = r_rs2;
        w_rs3_nxt       = r_rs3;
        w_proto_err_nxt = r_proto_err;
        if (w_in_fire) begin
            if ((r_state == S_IDLE) && !in_sop) begin
                w_proto_err_nxt = 1'b1;
            end else begin
                if (in_sop) begin
                    w_hdr_nxt   = in_hdr;
                    w_tmask_nxt = '0;
                    w_rs1_nxt   = '0;
                    w_rs2_nxt   = '0;
                    w_rs3_nxt   = '0;
                    if (r_state == S_GATHER) w_proto_err_nxt = 1'b1;
                end
                if (!w_sid_ok) w_proto_err_nxt = 1'b1;
                for (int unsigned s = 0; s < SIMD_COUNT; s++) begin
                    if (w_sid_ok && (in_sid == SID_W'(s))) begin
                        w_tmask_nxt[s*SIMD_WIDTH +: SIMD_WIDTH] = in_tmask;
                        w_rs1_nxt[s*SLICE_W +: SLICE_W]         = in_rs1_data;
                        w_rs2_nxt[s*SLICE_W +: SLICE_W]         = in_rs2_data;
                        w_rs3_nxt[s*SLICE_W +: SLICE_W]         = in_rs3_data;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_hdr       <= '0;
            r_tmask     <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rs3       <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hdr       <= w_hdr_nxt;
            r_tmask     <= w_tmask_nxt;
            r_rs1       <= w_rs1_nxt;
            r_rs2       <= w_rs2_nxt;
            r_rs3       <= w_rs3_nxt;
            r_proto_err <= w_proto_err_nxt;
        end
    end

`ifdef TENSOR_GATHER_PERF_EN
    logic [31:0] r_perf_stalls;

    // Saturating count of cycles the full packet waits on the consumer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_stalls <= '0;
        end else if ((r_state == S_FULL) && !out_ready && (r_perf_stalls != 32'hFFFF_FFFF)) begin
            r_perf_stalls <= r_perf_stalls + 32'd1;
        end
    end

    assign perf_stalls = r_perf_stalls;
`else
    assign perf_stalls = '0;
`endif

    assign in_ready     = (r_state != S_FULL);
    assign out_valid    = (r_state == S_FULL);
    assign out_hdr      = r_hdr;
    assign out_tmask    = r_tmask;
    assign out_rs1_data = r_rs1;
    assign out_rs2_data = r_rs2;
    assign out_rs3_data = r_rs3;
    assign proto_err    = r_proto_err;

endmodule

// File: tb/tb_vx_tensor_gather.sv
// Self-checking bench for vx_tensor_gather: directed vector table, reset corners,
// then randomized traffic against a lane-array reference model.
module tb_vx_tensor_gather;

    localparam int unsigned NT   = 4;
    localparam int unsigned SW   = 2;
    localparam int unsigned XL   = 32;
    localparam int unsigned HW   = 64;
    localparam int unsigned SC   = NT / SW;
    localparam int unsigned SIDW = (SC > 1) ? $clog2(SC) : 1;
`ifdef TENSOR_GATHER_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [HW-1:0]    in_hdr;
    logic [SIDW-1:0]  in_sid;
    logic [SW-1:0]    in_tmask;
    logic [SW*XL-1:0] in_rs1_data, in_rs2_data, in_rs3_data;
    logic             in_sop, in_eop;
    logic             out_valid;
    logic             out_ready;
    logic [HW-1:0]    out_hdr;
    logic [NT-1:0]    out_tmask;
    logic [NT*XL-1:0] out_rs1_data, out_rs2_data, out_rs3_data;
    logic             proto_err;
    logic [31:0]      perf_stalls;

    vx_tensor_gather #(
        .NUM_THREADS (NT),
        .SIMD_WIDTH  (SW),
        .XLEN        (XL),
        .HDR_W       (HW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_hdr       (in_hdr),
        .in_sid       (in_sid),
        .in_tmask     (in_tmask),
        .in_rs1_data  (in_rs1_data),
        .in_rs2_data  (in_rs2_data),
        .in_rs3_data  (in_rs3_data),
        .in_sop       (in_sop),
        .in_eop       (in_eop),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_hdr      (out_hdr),
        .out_tmask    (out_tmask),
        .out_rs1_data (out_rs1_data),
        .out_rs2_data (out_rs2_data),
        .out_rs3_data (out_rs3_data),
        .proto_err    (proto_err),
        .perf_stalls  (perf_stalls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    typedef struct {
        bit            rst;
        bit            vld;
        bit            sop;
        bit            eop;
        logic [SIDW-1:0] sid;
        logic [SW-1:0] tm;
        logic [SW*XL-1:0] rs1;
        logic [HW-1:0] hdr;
        bit            ordy;
        bit            e_vld;
        bit            e_err;
        logic [NT-1:0] e_tm;
        logic [NT*XL-1:0] e_rs1;
        logic [HW-1:0] e_hdr;
        int            e_perf;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(bit rst, bit vld, bit sop, bit eop, logic [SIDW-1:0] sid,
                                logic [SW-1:0] tm, logic [SW*XL-1:0] rs1, logic [HW-1:0] hdr,
                                bit ordy, bit e_vld, bit e_err, logic [NT-1:0] e_tm,
                                logic [NT*XL-1:0] e_rs1, logic [HW-1:0] e_hdr, int e_perf);
        vec_t v;
        v.rst = rst; v.vld = vld; v.sop = sop; v.eop = eop; v.sid = sid; v.tm = tm;
        v.rs1 = rs1; v.hdr = hdr; v.ordy = ordy; v.e_vld = e_vld; v.e_err = e_err;
        v.e_tm = e_tm; v.e_rs1 = e_rs1; v.e_hdr = e_hdr; v.e_perf = e_perf;
        return v;
    endfunction

    // Reference model: per-lane arrays filled from slice arithmetic lane = sid*SW + j.
    bit               m_full, m_coll, m_err;
    bit               m_tm[NT];
    logic [XL-1:0]    m_rs[3][NT];
    logic [HW-1:0]    m_hdr;
    longint           m_perf;

    function automatic void model_reset();
        m_full = 0; m_coll = 0; m_err = 0; m_hdr = '0; m_perf = 0;
        for (int i = 0; i < NT; i++) begin
            m_tm[i] = 0;
            for (int k = 0; k < 3; k++) m_rs[k][i] = '0;
        end
    endfunction

    function automatic void model_accept(bit sop, bit eop, int sid, logic [SW-1:0] tm,
                                         logic [SW*XL-1:0] r1, logic [SW*XL-1:0] r2,
                                         logic [SW*XL-1:0] r3, logic [HW-1:0] hdr);
        if (!m_coll && !sop) begin
            m_err = 1;
            return;
        end
        if (sop) begin
            if (m_coll) m_err = 1;
            m_hdr = hdr;
            for (int i = 0; i < NT; i++) begin
                m_tm[i] = 0;
                for (int k = 0; k < 3; k++) m_rs[k][i] = '0;
            end
        end
        if (sid < int'(SC)) begin
            for (int j = 0; j < SW; j++) begin
                m_tm[sid*SW + j]    = tm[j];
                m_rs[0][sid*SW + j] = r1[j*XL +: XL];
                m_rs[1][sid*SW + j] = r2[j*XL +: XL];
                m_rs[2][sid*SW + j] = r3[j*XL +: XL];
            end
        end else begin
            m_err = 1;
        end
        if (eop) begin
            m_full = 1;
            m_coll = 0;
        end else begin
            m_coll = 1;
        end
    endfunction

    function automatic logic [NT*XL-1:0] pack_rs(int k);
        logic [NT*XL-1:0] r;
        for (int i = 0; i < NT; i++) r[i*XL +: XL] = m_rs[k][i];
        return r;
    endfunction

    function automatic logic [NT-1:0] pack_tm();
        logic [NT-1:0] r;
        for (int i = 0; i < NT; i++) r[i] = m_tm[i];
        return r;
    endfunction

    function automatic void compare_model(string tag);
        chk({tag, ".out_valid"}, 256'(out_valid), 256'(m_full));
        chk({tag, ".in_ready"},  256'(in_ready),  256'(!m_full));
        chk({tag, ".proto_err"}, 256'(proto_err), 256'(m_err));
        chk({tag, ".out_hdr"},   256'(out_hdr),   256'(m_hdr));
        chk({tag, ".out_tmask"}, 256'(out_tmask), 256'(pack_tm()));
        chk({tag, ".rs1"},       256'(out_rs1_data), 256'(pack_rs(0)));
        chk({tag, ".rs2"},       256'(out_rs2_data), 256'(pack_rs(1)));
        chk({tag, ".rs3"},       256'(out_rs3_data), 256'(pack_rs(2)));
        chk({tag, ".perf"},      256'(perf_stalls), PERF ? 256'(m_perf) : 256'(0));
    endfunction

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic pulse_reset(string tag);
        #2 reset = 1'b1;
        #1;
        chk({tag, ".rst_out_valid"}, 256'(out_valid), 256'(0));
        chk({tag, ".rst_proto_err"}, 256'(proto_err), 256'(0));
        chk({tag, ".rst_in_ready"},  256'(in_ready),  256'(1));
        chk({tag, ".rst_tmask"},     256'(out_tmask), 256'(0));
        chk({tag, ".rst_perf"},      256'(perf_stalls), 256'(0));
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic drive(bit vld, bit sop, bit eop, logic [SIDW-1:0] sid, logic [SW-1:0] tm,
                         logic [SW*XL-1:0] r1, logic [HW-1:0] hdr, bit ordy);
        in_valid = vld; in_sop = sop; in_eop = eop; in_sid = sid; in_tmask = tm;
        in_rs1_data = r1; in_rs2_data = ~r1; in_rs3_data = r1 ^ {SW{32'h5A5A_0F0F}};
        in_hdr = hdr; out_ready = ordy;
    endtask

    task automatic run_random(int cycles);
        bit acc, ofire, sop, eop;
        logic [SIDW-1:0] sid;
        logic [SW-1:0] tm;
        logic [SW*XL-1:0] r1, r2, r3;
        logic [HW-1:0] hdr;
        for (int c = 0; c < cycles; c++) begin
            sop = m_coll ? ($urandom_range(99) < 15) : ($urandom_range(99) < 55);
            eop = ($urandom_range(99) < 40);
            sid = SIDW'($urandom_range(SC - 1));
            tm  = SW'($urandom);
            r1  = {$urandom, $urandom};
            r2  = {$urandom, $urandom};
            r3  = {$urandom, $urandom};
            hdr = {$urandom, $urandom};
            in_valid = ($urandom_range(99) < 75);
            in_sop = sop; in_eop = eop; in_sid = sid; in_tmask = tm;
            in_rs1_data = r1; in_rs2_data = r2; in_rs3_data = r3; in_hdr = hdr;
            out_ready = ($urandom_range(99) < 60);
            acc   = in_valid && !m_full;
            ofire = m_full && out_ready;
            if (m_full && !out_ready && m_perf != 64'hFFFF_FFFF) m_perf++;
            @(posedge clk);
            @(negedge clk);
            if (ofire) m_full = 0;
            if (acc) model_accept(sop, eop, int'(sid), tm, r1, r2, r3, hdr);
            compare_model($sformatf("rnd%0d", c));
        end
    endtask

    initial begin
        tbl[0]  = mk(0,0,0,0,0,2'b00,64'h0,64'h0,1, 0,0,4'b0000,128'h0,64'h0,0);
        tbl[1]  = mk(0,1,1,0,0,2'b11,64'h00000002_00000001,64'h1234,1,
                     0,0,4'b0011,128'h00000002_00000001,64'h1234,0);
        tbl[2]  = mk(0,1,0,1,1,2'b01,64'h00000000_00000003,64'hDEAD,1,
                     1,0,4'b0111,128'h00000000_00000003_00000002_00000001,64'h1234,0);
        tbl[3]  = mk(0,0,0,0,0,2'b00,64'h0,64'h0,1,
                     0,0,4'b0111,128'h00000000_00000003_00000002_00000001,64'h1234,0);
        tbl[4]  = mk(0,1,1,1,1,2'b10,64'h0000000B_0000000A,64'h55,0,
                     1,0,4'b1000,128'h0000000B_0000000A_00000000_00000000,64'h55,0);
        for (int k = 5; k <= 9; k++)
            tbl[k] = mk(0,1,1,0,0,2'b11,64'hFFFFFFFF_FFFFFFFF,64'h99,0,
                        1,0,4'b1000,128'h0000000B_0000000A_00000000_00000000,64'h55,k-4);
        tbl[10] = mk(0,0,0,0,0,2'b00,64'h0,64'h0,1,
                     0,0,4'b1000,128'h0000000B_0000000A_00000000_00000000,64'h55,5);
        tbl[11] = mk(0,1,1,0,0,2'b01,64'h00000000_00000011,64'hA,1,
                     0,0,4'b0001,128'h11,64'hA,5);
        tbl[12] = mk(0,1,1,0,0,2'b10,64'h00000022_00000000,64'hB,1,
                     0,1,4'b0010,128'h00000022_00000000,64'hB,5);
        tbl[13] = mk(0,1,0,1,1,2'b11,64'h00000044_00000033,64'hC,1,
                     1,1,4'b1110,128'h00000044_00000033_00000022_00000000,64'hB,5);
        tbl[14] = mk(0,0,0,0,0,2'b00,64'h0,64'h0,1,
                     0,1,4'b1110,128'h00000044_00000033_00000022_00000000,64'hB,5);
        tbl[15] = mk(1,1,0,1,0,2'b11,64'h77,64'hE,1, 0,1,4'b0000,128'h0,64'h0,0);
        tbl[16] = mk(0,0,0,0,0,2'b00,64'h0,64'h0,1, 0,1,4'b0000,128'h0,64'h0,0);
        tbl[17] = mk(0,1,1,0,0,2'b01,64'h5,64'hF,1, 0,1,4'b0001,128'h5,64'hF,0);

        reset = 1'b1;
        drive(0,0,0,0,2'b00,'0,'0,1);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        foreach (tbl[i]) begin
            if (tbl[i].rst) pulse_reset($sformatf("row%0d", i));
            drive(tbl[i].vld, tbl[i].sop, tbl[i].eop, tbl[i].sid, tbl[i].tm,
                  tbl[i].rs1, tbl[i].hdr, tbl[i].ordy);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("row%0d.out_valid", i), 256'(out_valid), 256'(tbl[i].e_vld));
            chk($sformatf("row%0d.in_ready", i),  256'(in_ready),  256'(!tbl[i].e_vld));
            chk($sformatf("row%0d.proto_err", i), 256'(proto_err), 256'(tbl[i].e_err));
            chk($sformatf("row%0d.out_tmask", i), 256'(out_tmask), 256'(tbl[i].e_tm));
            chk($sformatf("row%0d.out_rs1", i),   256'(out_rs1_data), 256'(tbl[i].e_rs1));
            chk($sformatf("row%0d.out_hdr", i),   256'(out_hdr), 256'(tbl[i].e_hdr));
            chk($sformatf("row%0d.perf", i),      256'(perf_stalls),
                PERF ? 256'(tbl[i].e_perf) : 256'(0));
        end

        // Reset while gathering (table ends mid-GATHER), then a stray eop must not emit.
        drive(0,0,0,0,2'b00,'0,'0,1);
        pulse_reset("mid_gather");
        drive(1,0,1,1,2'b11,64'h1,64'h2,1);
        @(posedge clk);
        @(negedge clk);
        drive(0,0,0,0,2'b00,'0,'0,1);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("post_rst_idle%0d.out_valid", c), 256'(out_valid), 256'(0));
            @(negedge clk);
        end

        // Reset while FULL and stalled discards the packet.
        drive(1,1,1,0,2'b11,64'h00000009_00000008,64'h77,0);
        @(posedge clk);
        @(negedge clk);
        drive(0,0,0,0,2'b00,'0,'0,0);
        chk("full_before_rst.out_valid", 256'(out_valid), 256'(1));
        chk("full_before_rst.out_tmask", 256'(out_tmask), 256'(4'b0011));
        pulse_reset("mid_full");
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_full_rst.out_valid", 256'(out_valid), 256'(0));
        chk("post_full_rst.in_ready",  256'(in_ready),  256'(1));

        pulse_reset("random_start");
        run_random(3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vx_tensor_gather.md
VX_TENSOR_GATHER -- requirements
Module: VX_tensor_gather
Purpose: downstream of tensor operand stage; reassembles SIMD-slice operand packets (sid/sop/eop) into one full-warp packet for the tensor core.

Interface
REQ-001 SHALL have parameter NUM_THREADS, default 4, warp width in lanes.
REQ-002 SHALL have parameter SIMD_WIDTH, default 2, lanes per input slice; NUM_THREADS divisible by SIMD_WIDTH; SIMD_COUNT=NUM_THREADS/SIMD_WIDTH; SID_W=max(1,clog2(SIMD_COUNT)).
REQ-003 SHALL have parameter XLEN, default 32, bits per lane operand.
REQ-004 SHALL have parameter HDR_W, default 64, opaque header bits (uuid, wis, PC, ex/op, args, wb, rd).
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 reset  input  1  asynchronous, active-high.
REQ-007 in_valid / in_ready  input / output  1 / 1  slice handshake.
REQ-008 in_hdr  input  HDR_W  header, meaningful on sop slice.
REQ-009 in_sid  input  SID_W  slice index.
REQ-010 in_tmask  input  SIMD_WIDTH  slice thread mask.
REQ-011 in_rs1_data, in_rs2_data, in_rs3_data  input  SIMD_WIDTH*XLEN each  slice operands.
REQ-012 in_sop, in_eop  input  1 each  first/last slice of instruction.
REQ-013 out_valid / out_ready  output / input  1 / 1  warp packet handshake.
REQ-014 out_hdr  output  HDR_W; out_tmask  output  NUM_THREADS; out_rs1_data, out_rs2_data, out_rs3_data  output  NUM_THREADS*XLEN each.
REQ-015 proto_err  output  1  sticky protocol-error flag.
REQ-016 perf_stalls  output  32  out_valid&&!out_ready cycle count.

Function
REQ-017 SHALL implement states IDLE, GATHER, FULL; slice accepted when in_valid&&in_ready.
REQ-018 in_ready SHALL be 1 in IDLE and GATHER, 0 in FULL.
REQ-019 Accepted sop slice SHALL clear out_tmask and all operand lanes to 0, latch in_hdr, then write its slice.
REQ-020 Accepted slice SHALL write tmask/operands to lanes [sid*SIMD_WIDTH +: SIMD_WIDTH]; lanes of unsent slices stay 0.
REQ-021 Transitions: IDLE+sop&&!eop -> GATHER; IDLE or GATHER +eop -> FULL; FULL+out fire -> IDLE.
REQ-022 Latency: eop accepted at cycle N -> out_valid=1 at N+1; out_valid SHALL equal (state==FULL).
REQ-023 Outputs SHALL hold stable while out_valid&&!out_ready.
REQ-024 Single-slice instruction (sop&&eop) SHALL go IDLE -> FULL directly.
REQ-025 Non-sop slice in IDLE SHALL be accepted and dropped, set proto_err, stay IDLE.
REQ-026 sop slice in GATHER SHALL discard partial packet, restart per REQ-019, set proto_err.
REQ-027 sid>=SIMD_COUNT SHALL set proto_err with no lane write; its eop still transitions.
REQ-028 proto_err SHALL remain 1 until reset.
REQ-029 Throughput: one warp packet per (slices+1) cycles minimum; no input bypass in FULL.

Reset
REQ-030 Reset SHALL asynchronously force state=IDLE, out_valid=0, in_ready=1, proto_err=0, perf_stalls=0, out_hdr/out_tmask/operands=0.
REQ-031 Reset mid-GATHER or mid-FULL SHALL discard the packet; no output after release until a new sop..eop completes.

Configuration
REQ-032 Macro TENSOR_GATHER_PERF_EN: defined -> perf_stalls increments each out_valid&&!out_ready cycle, saturating at 0xFFFFFFFF; undefined -> perf_stalls tied to 0, no counter logic.

Verification (NUM_THREADS=4, SIMD_WIDTH=2, XLEN=32)
REQ-033 Slices sid0 sop tmask=2'b11 rs1={0x2,0x1}, sid1 eop tmask=2'b01 rs1={0x0,0x3} -> next cycle out_valid=1, out_tmask=4'b0111, out_rs1={0,3,2,1}, out_hdr = sop hdr.
REQ-034 Single slice sop=eop=1 sid=1 tmask=2'b10 -> out_tmask=4'b1000, lanes 0-1 zero, proto_err=0.
REQ-035 out_ready=0 for 5 cycles after FULL -> outputs stable, in_ready=0; with TENSOR_GATHER_PERF_EN perf_stalls=5, without =0.
REQ-036 sid0 sop hdr=0xA, then sid0 sop hdr=0xB, then sid1 eop -> out_hdr=0xB, proto_err=1.
REQ-037 Eop-only slice in IDLE -> no out_valid, proto_err=1; assert reset mid-GATHER -> out_valid=0, proto_err=0 immediately.
